// File: rtl/alu_wide_sequencer.sv
// -----------------------------------------------------------------------------
// alu_wide_sequencer
//
// Purpose:
//   Issues one wide (WORDS x 32-bit) operation to an external combinational
//   32-bit ALU. It sends one word per cycle, least-significant word first.
//   For ADD, the carry is chained between words. The assembled result is
//   returned on a valid/ready response channel.
//   The FSM runs IDLE -> ISSUE -> RESP -> IDLE. Shift and cut opcodes have no
//   word-chaining meaning, so they go straight to RESP with rsp_err set.
//
// Parameters:
//   WORDS  number of 32-bit words per operand (1..8)
//   IDXW   word index width, derived from WORDS (minimum 1)
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_opcode            000 NOT, 001 AND, 010 OR, 011 XOR,
//                         100 SHL, 101 SHR, 110 CUT, 111 ADD
//   req_a, req_b          wide operands; word 0 is bits [31:0]
//   req_cin               initial carry (ADD only)
//   alu_opcode/a/b/cin    registered drive to the ALU; zero outside ISSUE
//   alu_result, alu_cout  combinational ALU response (same cycle)
//   rsp_valid/rsp_ready   response handshake
//   rsp_result            assembled wide result
//   rsp_cout              final carry out (ADD only, else 0)
//   rsp_err               unsupported opcode
//   perf_ops              (ALU_SEQ_PERF_EN only) saturating count of
//                         completed response handshakes
//
// Build option:
//   ALU_SEQ_PERF_EN  adds the perf_ops output and its counter.
// -----------------------------------------------------------------------------
module alu_wide_sequencer #(
  parameter  int unsigned WORDS = 2,
  localparam int unsigned IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_opcode,
  input  logic [32*WORDS-1:0]   req_a,
  input  logic [32*WORDS-1:0]   req_b,
  input  logic                  req_cin,
  // ALU interface
  output logic [2:0]            alu_opcode,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic                  alu_cin,
  input  logic [31:0]           alu_result,
  input  logic                  alu_cout,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [32*WORDS-1:0]   rsp_result,
  output logic                  rsp_cout,
`ifdef ALU_SEQ_PERF_EN
  output logic [31:0]           perf_ops,
`endif
  output logic                  rsp_err
);

  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_CUT = 3'b110;
  localparam logic [2:0] OP_ADD = 3'b111;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_e;

  state_e               state_q;
  logic [IDXW-1:0]      idx_q;
  logic                 carry_q;
  logic [2:0]           op_q;
  logic [32*WORDS-1:0]  a_q;
  logic [32*WORDS-1:0]  b_q;
  logic [32*WORDS-1:0]  result_q;

  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic                 rsp_cout_q;
  logic                 rsp_err_q;
  logic [2:0]           alu_opcode_q;
  logic [31:0]          alu_a_q;
  logic [31:0]          alu_b_q;
  logic                 alu_cin_q;

  logic [IDXW-1:0]      idx_d;
  logic                 op_is_add;
  logic                 req_unsupported;

  // Selects 32-bit word i of a wide operand.
  function automatic logic [31:0] word_of(input logic [32*WORDS-1:0] vec,
                                          input logic [IDXW-1:0]     i);
    return vec[32*i +: 32];
  endfunction

  assign idx_d           = idx_q + 1'b1;
  assign op_is_add       = (op_q == OP_ADD);
  assign req_unsupported = (req_opcode == OP_SHL) || (req_opcode == OP_SHR) ||
                           (req_opcode == OP_CUT);

  // The ALU drive is registered one stage ahead. On the edge that enters or
  // advances ISSUE, the word for the next cycle is loaded, so the ALU sees
  // word idx during the cycle in which idx_q == idx. The carry fed forward is
  // taken straight from alu_cout. That is the same value carry_q receives on
  // that edge, so the next word's cin equals the chained carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: every state element uses non-blocking assignment. Reads in this
      // block then see the values from before the edge, and the order of
      // statements does not change the result.
      state_q      <= S_IDLE;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_cout_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            op_q        <= req_opcode;
            a_q         <= req_a;
            b_q         <= req_b;
            idx_q       <= '0;
            carry_q     <= req_cin;
            result_q    <= '0;
            rsp_cout_q  <= 1'b0;
            req_ready_q <= 1'b0;
            if (req_unsupported) begin
              // No ALU cycles: the error response is presented immediately.
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q      <= S_ISSUE;
              rsp_err_q    <= 1'b0;
              alu_opcode_q <= req_opcode;
              alu_a_q      <= word_of(req_a, '0);
              alu_b_q      <= word_of(req_b, '0);
              alu_cin_q    <= (req_opcode == OP_ADD) ? req_cin : 1'b0;
            end
          end
        end

        S_ISSUE: begin
          result_q[32*idx_q +: 32] <= alu_result;
          if (op_is_add) begin
            carry_q <= alu_cout;
          end
          if (idx_q == LAST_IDX) begin
            // The carry out of the top word goes only to rsp_cout.
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_cout_q   <= op_is_add ? alu_cout : 1'b0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
          end else begin
            idx_q     <= idx_d;
            alu_a_q   <= word_of(a_q, idx_d);
            alu_b_q   <= word_of(b_q, idx_d);
            alu_cin_q <= op_is_add ? alu_cout : 1'b0;
          end
        end

        S_RESP: begin
          // rsp_result, rsp_err and rsp_cout are held until the handshake.
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_err    = rsp_err_q;

`ifdef ALU_SEQ_PERF_EN
  // Completed response handshakes, including error responses. The count
  // saturates at all-ones.
  logic [31:0] perf_ops_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ops_q <= '0;
    end else if (rsp_valid_q && rsp_ready && (perf_ops_q != '1)) begin
      perf_ops_q <= perf_ops_q + 32'd1;
    end
  end

  assign perf_ops = perf_ops_q;
`else
  // Performance counter not built.
`endif

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_wide_sequencer
//
// Directed bench for alu_wide_sequencer with WORDS=2. A small behavioural
// 32-bit ALU answers the DUT's per-word requests. Expected wide results are
// hand-computed constants. Inputs change 1 ns after the rising edge, and
// outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_alu_wide_sequencer;

  localparam int unsigned WORDS = 2;

  logic                clk;
  logic                rst_n;
  logic                req_valid;
  logic                req_ready;
  logic [2:0]          req_opcode;
  logic [32*WORDS-1:0] req_a;
  logic [32*WORDS-1:0] req_b;
  logic                req_cin;
  logic [2:0]          alu_opcode;
  logic [31:0]         alu_a;
  logic [31:0]         alu_b;
  logic                alu_cin;
  logic [31:0]         alu_result;
  logic                alu_cout;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [32*WORDS-1:0] rsp_result;
  logic                rsp_cout;
  logic                rsp_err;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0]         perf_ops;
  logic [31:0]         perf_before;
`endif

  int tests_run;
  int tests_failed;
  int seen_rsp;

  alu_wide_sequencer #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
`ifdef ALU_SEQ_PERF_EN
    .perf_ops   (perf_ops),
`endif
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference combinational 32-bit ALU.
  always_comb begin
    alu_result = '0;
    alu_cout   = 1'b0;
    unique case (alu_opcode)
      3'b000: alu_result = ~alu_a;
      3'b001: alu_result = alu_a & alu_b;
      3'b010: alu_result = alu_a | alu_b;
      3'b011: alu_result = alu_a ^ alu_b;
      3'b100: alu_result = alu_a << alu_b[4:0];
      3'b101: alu_result = alu_a >> alu_b[4:0];
      3'b110: alu_result = alu_a;
      3'b111: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one edge; returns in cycle 1 after acceptance.
  task automatic send(input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic cin);
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_cin    = cin;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    seen_rsp     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    req_cin    = 1'b0;
    rsp_ready  = 1'b0;
    step();
    step();

    // Reset state
    check("rst_req_ready",  req_ready,  1);
    check("rst_rsp_valid",  rsp_valid,  0);
    check("rst_alu_opcode", alu_opcode, 0);
    check("rst_rsp_result", rsp_result, 0);
    rst_n = 1'b1;
    step();

    // rsp_ready while idle is ignored
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("idle_rsp_ready_ign", rsp_valid, 0);
    check("idle_req_ready",     req_ready, 1);

    // ADD with carry chained from word 0 into word 1
    send(3'b111, 64'h00000000_FFFFFFFF, 64'h00000000_00000001, 1'b0);
    check("add1_c1_opcode", alu_opcode, 3'b111);
    check("add1_c1_a",      alu_a,      32'hFFFFFFFF);
    check("add1_c1_b",      alu_b,      32'h00000001);
    check("add1_c1_cin",    alu_cin,    0);
    check("add1_c1_rsp_v",  rsp_valid,  0);
    check("add1_c1_ready",  req_ready,  0);
    step();
    check("add1_c2_a",      alu_a,      32'h0);
    check("add1_c2_cin",    alu_cin,    1);
    check("add1_c2_rsp_v",  rsp_valid,  0);
    step();
    check("add1_c3_rsp_v",  rsp_valid,  1);
    check("add1_result",    rsp_result, 64'h00000001_00000000);
    check("add1_cout",      rsp_cout,   0);
    check("add1_err",       rsp_err,    0);
    check("add1_c3_alu_op", alu_opcode, 0);
    consume();
    check("add1_done_v",    rsp_valid,  0);
    check("add1_done_rdy",  req_ready,  1);

    // ADD: carry propagates through every word and out the top
    send(3'b111, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b1);
    check("add2_c1_cin",    alu_cin,    1);
    step();
    check("add2_c2_cin",    alu_cin,    1);
    step();
    check("add2_rsp_v",     rsp_valid,  1);
    check("add2_result",    rsp_result, 64'h0);
    check("add2_cout",      rsp_cout,   1);
    consume();

    // XOR: no carry involvement
    send(3'b011, 64'h12345678_AAAAAAAA, 64'hFFFFFFFF_55555555, 1'b1);
    check("xor_c1_opcode",  alu_opcode, 3'b011);
    check("xor_c1_cin",     alu_cin,    0);
    step();
    check("xor_c2_a",       alu_a,      32'h12345678);
    check("xor_c2_cin",     alu_cin,    0);
    step();
    check("xor_result",     rsp_result, 64'hEDCBA987_FFFFFFFF);
    check("xor_cout",       rsp_cout,   0);
    consume();

    // AND
    send(3'b001, 64'hFF00FF00_0F0F0F0F, 64'h0FF00FF0_FFFF0000, 1'b0);
    step();
    step();
    check("and_result",     rsp_result, 64'h0F000F00_0F0F0000);
    check("and_err",        rsp_err,    0);
    consume();

    // SHL: unsupported, immediate error response with no ALU cycle
    send(3'b100, 64'h1, 64'h1, 1'b0);
    check("shl_rsp_v",      rsp_valid,  1);
    check("shl_err",        rsp_err,    1);
    check("shl_result",     rsp_result, 64'h0);
    check("shl_cout",       rsp_cout,   0);
    check("shl_alu_opcode", alu_opcode, 0);
    check("shl_req_ready",  req_ready,  0);
    consume();
    check("shl_done_v",     rsp_valid,  0);
    check("shl_done_rdy",   req_ready,  1);

    // ADD with a stalled response; new requests during RESP are ignored
`ifdef ALU_SEQ_PERF_EN
    perf_before = perf_ops;
`endif
    send(3'b111, 64'h00000000_00000003, 64'h00000000_00000005, 1'b0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      req_valid  = 1'b1;
      req_opcode = 3'b011;
      req_a      = 64'hDEAD;
      check($sformatf("stall%0d_rsp_v", i),  rsp_valid,  1);
      check($sformatf("stall%0d_result", i), rsp_result, 64'h8);
      check($sformatf("stall%0d_err", i),    rsp_err,    0);
      check($sformatf("stall%0d_ready", i),  req_ready,  0);
      step();
    end
    req_valid = 1'b0;
    consume();
    check("stall_done_v",   rsp_valid,  0);
    check("stall_done_rdy", req_ready,  1);
    check("stall_no_issue", alu_opcode, 0);
`ifdef ALU_SEQ_PERF_EN
    check("perf_inc",       perf_ops,   perf_before + 32'd1);
`endif

    // Reset during the first ISSUE cycle aborts the transaction
    send(3'b111, 64'h11111111_22222222, 64'h1, 1'b0);
    check("abort_in_issue", alu_opcode, 3'b111);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_rsp_v",    rsp_valid,  0);
    check("abort_alu_op",   alu_opcode, 0);
    check("abort_alu_a",    alu_a,      0);
    check("abort_alu_cin",  alu_cin,    0);
    check("abort_ready",    req_ready,  1);
    check("abort_result",   rsp_result, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid) seen_rsp++;
    end
    rsp_ready = 1'b0;
    check("abort_no_rsp",   seen_rsp,   0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
